// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned LANE_N    = WORD_W / BYTE_W;
    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // True for the states that belong to a frame in progress.
    function automatic logic is_frame_state(input state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_word_pack.sv
// Little-endian byte-to-word packer with running XOR checksum.
// word_valid_o pulses for one cycle, the cycle after the 4th byte of a word.
module imem_word_pack
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic [BYTE_W-1:0] xor_o,
    output logic              last_lane_c
);

    logic [2:0][BYTE_W-1:0] lane_q;
    logic [1:0]             idx_q;

    // The incoming byte completes a word when it lands in the top lane.
    assign last_lane_c = (idx_q == 2'd3);

    // Lane index and checksum accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= 2'd0;
            xor_o <= '0;
        end else if (clear_i) begin
            idx_q <= 2'd0;
            xor_o <= '0;
        end else if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
            xor_o <= xor_o ^ byte_i;
        end
    end

    // Lower lanes hold bytes 0..2; byte 3 is merged straight into the word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q       <= '0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
        end else begin
            word_valid_o <= 1'b0;
            if (byte_valid_i && !clear_i) begin
                case (idx_q)
                    2'd0:    lane_q[0] <= byte_i;
                    2'd1:    lane_q[1] <= byte_i;
                    2'd2:    lane_q[2] <= byte_i;
                    default: begin
                        word_o       <= {byte_i, lane_q[2], lane_q[1], lane_q[0]};
                        word_valid_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader feeding the instruction memory write port.
// Frame: 0xA5, LEN_LO, LEN_HI, LEN*4 data bytes (LSB first), XOR checksum.
// Optional build macro IMEM_LOADER_TIMEOUT_EN aborts a frame after
// TIMEOUT_CYC cycles without an accepted byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_W      = 32,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    output logic              rx_ready_o,
    output logic              wr_en_o,
    output logic [IMEM_W-1:0] wr_addr_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_t state_q, state_d;

    logic              hs_c;
    logic [BYTE_W-1:0] len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_new_c;
    logic [LEN_W-1:0]  word_idx_q;
    logic              last_word_c;
    logic              timeout_c;

    logic              start_c;
    logic              latch_lo_c;
    logic              latch_len_c;
    logic              pack_clear_c;
    logic              pack_byte_c;
    logic              take_word_c;

    logic              pack_word_valid;
    logic [WORD_W-1:0] pack_word;
    logic [BYTE_W-1:0] pack_xor;
    logic              last_lane_c;

    assign hs_c        = rx_valid_i && rx_ready_o;
    assign len_new_c   = LEN_W'({rx_data_i, len_lo_q});
    assign last_word_c = (word_idx_q == (len_q - LEN_W'(1)));

    // Byte lanes, lane index and checksum live in the packer.
    imem_word_pack u_pack (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (pack_clear_c),
        .byte_valid_i (pack_byte_c),
        .byte_i       (rx_data_i),
        .word_valid_o (pack_word_valid),
        .word_o       (pack_word),
        .xor_o        (pack_xor),
        .last_lane_c  (last_lane_c)
    );

    // Write strobe and data come straight from the packer's output flops.
    assign wr_en_o   = pack_word_valid;
    assign wr_data_o = pack_word;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Cycles since the last accepted byte while a frame is open.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else if (!is_frame_state(state_q) || hs_c) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign timeout_c = is_frame_state(state_q) && !hs_c &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Frame sequencing and per-cycle datapath controls.
    always_comb begin
        state_d      = state_q;
        start_c      = 1'b0;
        latch_lo_c   = 1'b0;
        latch_len_c  = 1'b0;
        pack_clear_c = 1'b0;
        pack_byte_c  = 1'b0;
        take_word_c  = 1'b0;

        case (state_q)
            IDLE: begin
                // Keeps the checksum at zero so an empty frame compares against 0x00.
                pack_clear_c = 1'b1;
                if (hs_c && (rx_data_i == SYNC_BYTE)) begin
                    start_c = 1'b1;
                    state_d = LEN0;
                end
            end
            LEN0: begin
                if (hs_c) begin
                    latch_lo_c = 1'b1;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (hs_c) begin
                    latch_len_c = 1'b1;
                    if (32'(len_new_c) > 32'(DEPTH_WORDS)) begin
                        state_d = ERR;
                    end else if (len_new_c == '0) begin
                        state_d = CSUM;
                    end else begin
                        pack_clear_c = 1'b1;
                        state_d      = DATA;
                    end
                end
            end
            DATA: begin
                if (hs_c) begin
                    pack_byte_c = 1'b1;
                    if (last_lane_c) begin
                        take_word_c = 1'b1;
                        if (last_word_c) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (hs_c) begin
                    state_d = (rx_data_i == pack_xor) ? DONE : ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timeout_c) begin
            state_d = ERR;
        end
    end

    // State register and registered status outputs, derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rx_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            cpu_hold_o <= 1'b1;
        end else begin
            state_q    <= state_d;
            rx_ready_o <= (state_d != DONE) && (state_d != ERR);
            busy_o     <= is_frame_state(state_d);
            if (start_c) begin
                done_o     <= 1'b0;
                err_o      <= 1'b0;
                cpu_hold_o <= 1'b1;
            end
            if (state_d == DONE) begin
                done_o     <= 1'b1;
                cpu_hold_o <= 1'b0;
            end
            if (state_d == ERR) begin
                err_o <= 1'b1;
            end
        end
    end

    // Frame length capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_lo_q <= '0;
            len_q    <= '0;
        end else begin
            if (latch_lo_c) begin
                len_lo_q <= rx_data_i;
            end
            if (latch_len_c) begin
                len_q <= len_new_c;
            end
        end
    end

    // Word index and the write address presented alongside the strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_idx_q <= '0;
            wr_addr_o  <= '0;
        end else begin
            if (latch_len_c) begin
                word_idx_q <= '0;
            end else if (take_word_c) begin
                word_idx_q <= word_idx_q + LEN_W'(1);
            end
            if (take_word_c) begin
                wr_addr_o <= IMEM_W'({word_idx_q, 2'b00});
            end
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream boot loader; the write side of the single-cycle core's instruction memory.
- Receives a framed program image over a byte valid/ready stream, e.g. from the UART RX block.
- Packs the bytes little-endian into 32-bit words and issues one-cycle write strobes to the instruction memory write port.
- Holds the CPU in reset while loading, and reports done/error status.

Parameters:
- IMEM_W, 32, width of the byte address driven on wr_addr_o.
- DEPTH_WORDS, 4096, instruction memory capacity in words; the image length limit.
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk_i cycles; used only with the optional feature.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- rx_valid_i  in  1  byte available
- rx_data_i  in  8  received byte
- rx_ready_o  out  1  loader accepts a byte; a byte transfers when valid&&ready
- wr_en_o  out  1  one-cycle instruction memory write strobe
- wr_addr_o  out  IMEM_W  byte address, always word aligned ([1:0]=0)
- wr_data_o  out  32  word to write
- cpu_hold_o  out  1  holds the core in reset while loading
- busy_o  out  1  frame in progress
- done_o  out  1  sticky: last frame loaded with a good checksum
- err_o  out  1  sticky: last frame failed

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high, rst_i.
- Reset values: rx_ready_o=0; wr_en_o=0; wr_addr_o=0; wr_data_o=0; cpu_hold_o=1; busy_o=0; done_o=0; err_o=0. All outputs are registered.
- Frame format: SYNC byte 0xA5, LEN_LO, LEN_HI (word count N), N*4 data bytes (LSB first per word), CSUM.
- CSUM is the XOR of all data bytes. For N=0 the expected CSUM is 0x00.
- rx_ready_o is 1 in every state except ERR and DONE. A transfer is counted only when valid&&ready.
- FSM transitions:
  - IDLE: a non-0xA5 byte is dropped. 0xA5 -> LEN0; clear done_o and err_o; set busy_o=1 and cpu_hold_o=1.
  - LEN0 -> LEN1: latch the low length byte.
  - LEN1: latch the high byte.
    - N > DEPTH_WORDS -> ERR.
    - N == 0 -> CSUM.
    - Otherwise -> DATA, with word address 0, byte index 0, xor accumulator 0.
  - DATA:
    - Each byte goes into lane byte_idx and is XORed into the accumulator; byte_idx increments mod 4.
    - On the 4th byte, wr_en_o=1 on the next cycle with the assembled word and the current address; the address then advances by 4.
    - The loader keeps accepting bytes during that write cycle (back-to-back bytes every cycle are legal).
    - After word N has been written, -> CSUM.
  - CSUM: compare the byte with the accumulator. Match -> DONE; mismatch -> ERR.
  - DONE (1 cycle): done_o=1, busy_o=0, cpu_hold_o=0 -> IDLE.
  - ERR (1 cycle): err_o=1, busy_o=0, cpu_hold_o stays 1 -> IDLE.
- Write latency: the strobe is asserted exactly 1 cycle after the handshake of the word's 4th byte.
- Write address: wr_addr_o = word_index<<2. It never exceeds (DEPTH_WORDS-1)<<2, so no wrap-around is possible.
- A 0xA5 byte inside DATA or LEN is treated as data; there is no resync mid-frame.
- Reset mid-frame: all state is lost, nothing is written, and cpu_hold_o returns to 1.

Optional Feature:
- Macro: IMEM_LOADER_TIMEOUT_EN.
- With the macro defined: in LEN0, LEN1, DATA and CSUM a counter counts cycles with no handshake.
  - Reaching TIMEOUT_CYC -> ERR.
  - The counter clears on every accepted byte and in IDLE.
- Without the macro: no counter; the loader waits indefinitely, and TIMEOUT_CYC is unused.

Decomposition:
- imem_loader_pkg:
  - state enum: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR
  - SYNC_BYTE = 8'hA5
  - LEN_W = 16
- Sub-module imem_word_pack: byte lane shifter plus byte_idx counter plus XOR accumulator.
  - Outputs word_valid, word and xor.
  - Cleared by the FSM on entry to DATA.

Test Plan:
- Basic load: 0xA5,0x02,0x00, bytes 0x13,0x00,0x00,0x00,0xB7,0x12,0x00,0x00, CSUM 0xB6.
  - Required: writes (0x0, 0x00000013) then (0x4, 0x000012B7).
  - Required: done_o=1, cpu_hold_o=0, err_o=0.
- Bad checksum: same frame with CSUM 0x00.
  - Required: both writes occur, then err_o=1, cpu_hold_o=1, done_o=0.
- Oversize: 0xA5,0x01,0x10 (N=4097).
  - Required: ERR right after LEN_HI, no wr_en_o pulse.
- Zero length and junk: leading junk 0x00,0xFF is ignored, then 0xA5,0x00,0x00,0x00.
  - Required: done_o=1, no writes.
- Back-to-back stress: rx_valid_i held high for a 16-word frame with random gaps, then a second frame.
  - Required: every write lands 1 cycle after its 4th byte; the second frame's sync clears done_o.
  - Required: reset asserted mid-DATA -> all outputs at reset values immediately.
  - With IMEM_LOADER_TIMEOUT_EN and TIMEOUT_CYC=50: stall 50 cycles inside DATA -> err_o=1.
